// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and staged system/peripheral reset release.
// Runs from the free-running reference clock so it keeps working while the PLL is unlocked.
module pll_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
  parameter int unsigned RELEASE_STAGGER     = 8,
  parameter int unsigned CNT_W               = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       periph_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  localparam int unsigned RETRY_W = 8;

  localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'(RELEASE_STAGGER - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = '1;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN_SYS,
    ST_RUN_ALL
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lost_nxt;
  logic               sync_q, locked_s;

  // Two-flop synchroniser: the only consumer of the asynchronous lock flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_PLL_RST;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_rst_n    <= 1'b0;
      periph_rst_n <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      retry_count  <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pll_rst      <= (state_nxt == ST_PLL_RST);
      sys_rst_n    <= (state_nxt == ST_RUN_SYS) || (state_nxt == ST_RUN_ALL);
      periph_rst_n <= (state_nxt == ST_RUN_ALL);
      ready        <= (state_nxt == ST_RUN_ALL);
      lock_lost    <= lost_nxt;
      retry_count  <= retry_nxt;
    end
  end

  // Next state; lock loss while released overrides any pending stagger step
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_nxt = retry_count;
    lost_nxt  = 1'b0;
    case (state)
      ST_PLL_RST: begin
        if (cnt == PLL_RST_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = ST_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_PLL_RST;
          if (retry_count != RETRY_MAX) retry_nxt = retry_count + RETRY_W'(1);
        end
      end
      ST_STABLE: begin
        if (!locked_s)                state_nxt = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nxt = ST_RUN_SYS;
      end
      ST_RUN_SYS: begin
        if (!locked_s) begin
          state_nxt = ST_PLL_RST;
          lost_nxt  = 1'b1;
        end else if (cnt == STAGGER_LAST) begin
          state_nxt = ST_RUN_ALL;
        end
      end
      ST_RUN_ALL: begin
        cnt_nxt = cnt;
        if (!locked_s) begin
          state_nxt = ST_PLL_RST;
          lost_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_PLL_RST;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a segment-level reference model predicts every
// output change from the lock waveform; a negedge monitor pops and compares on each change.
module tb_pll_reset_sequencer;

  localparam int unsigned LS = 4;
  localparam int unsigned PR = 3;
  localparam int unsigned TO = 10;
  localparam int unsigned RS = 2;
  localparam int unsigned CW = 8;
  localparam int MAXN = 3400;

  localparam int M_RST  = 0;
  localparam int M_WAIT = 1;
  localparam int M_STAB = 2;
  localparam int M_SYS  = 3;
  localparam int M_ALL  = 4;

  localparam logic [12:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst_n, periph_rst_n, ready, lock_lost;
  logic [7:0] retry_count;

  typedef struct {
    int          edge_no;
    logic [12:0] v;
  } ev_t;

  ev_t         exp_q[$];
  bit          lk[0:MAXN];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [12:0] prev = RST_VEC;
  logic [12:0] model_final;

  always #10 clk = ~clk;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (LS),
    .PLL_RST_CYCLES     (PR),
    .LOCK_TIMEOUT_CYCLES(TO),
    .RELEASE_STAGGER    (RS),
    .CNT_W              (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .periph_rst_n(periph_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  function automatic logic [12:0] outv();
    return {pll_rst, sys_rst_n, periph_rst_n, ready, lock_lost, retry_count};
  endfunction

  function automatic logic [12:0] mk(input int ph, input bit lost, input int rc);
    return {(ph == M_RST), (ph >= M_SYS), (ph == M_ALL), (ph == M_ALL), lost, 8'(rc)};
  endfunction

  // Synchronised lock as seen by the sequencer at edge e (two edges of latency)
  function automatic bit ls(input int e, input int n);
    return (e >= 3 && e - 2 <= n) ? lk[e-2] : 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
  endtask

  // Walks the lock history phase by phase, pushing each predicted output change
  task automatic build_expect(input int n);
    int ph, t, rc, te, nx;
    bit lost;
    logic [12:0] cur, nv;
    ph = M_RST; t = 0; rc = 0;
    cur = mk(M_RST, 1'b0, 0);
    exp_q.delete();
    forever begin
      lost = 1'b0; te = -1; nx = M_RST;
      case (ph)
        M_RST: begin
          te = t + PR; nx = M_WAIT;
        end
        M_WAIT: begin
          for (int e = t + 1; e <= t + TO; e++)
            if (ls(e, n)) begin te = e; nx = M_STAB; break; end
          if (te < 0) begin
            te = t + TO; nx = M_RST;
            rc = (rc < 255) ? rc + 1 : 255;
          end
        end
        M_STAB: begin
          for (int e = t + 1; e <= t + LS; e++)
            if (!ls(e, n)) begin te = e; nx = M_WAIT; break; end
          if (te < 0) begin te = t + LS; nx = M_SYS; end
        end
        M_SYS: begin
          for (int e = t + 1; e <= t + RS; e++)
            if (!ls(e, n)) begin te = e; nx = M_RST; lost = 1'b1; break; end
          if (te < 0) begin te = t + RS; nx = M_ALL; end
        end
        default: begin
          for (int e = t + 1; e <= n; e++)
            if (!ls(e, n)) begin te = e; nx = M_RST; lost = 1'b1; break; end
          if (te < 0) te = n + 1;
        end
      endcase
      if (te > n) break;
      nv = mk(nx, lost, rc);
      if (nv !== cur) exp_q.push_back('{te, nv});
      cur = nv;
      if (lost && te + 1 <= n) begin
        nv = mk(nx, 1'b0, rc);
        exp_q.push_back('{te + 1, nv});
        cur = nv;
      end
      ph = nx; t = te;
    end
    model_final = cur;
  endtask

  task automatic fill(input int kind, input int n);
    int e, len;
    bit val;
    for (int i = 0; i <= MAXN; i++) lk[i] = 1'b0;
    case (kind)
      0: for (int i = 4; i <= n; i++) lk[i] = 1'b1;
      1: ;
      2: begin
        lk[4] = 1'b1; lk[5] = 1'b1;
        for (int i = 7; i <= n; i++) lk[i] = 1'b1;
      end
      3: begin
        for (int i = 4; i <= 19; i++) lk[i] = 1'b1;
        for (int i = 26; i <= n; i++) lk[i] = 1'b1;
      end
      4: begin
        for (int i = 4; i <= 9; i++) lk[i] = 1'b1;
        for (int i = 16; i <= n; i++) lk[i] = 1'b1;
      end
      default: begin
        e = 1;
        val = 1'($urandom_range(0, 1));
        while (e <= n) begin
          len = val ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 14));
          for (int k = 0; k < len && e <= n; k++) begin lk[e] = val; e++; end
          val = !val;
        end
      end
    endcase
  endtask

  task automatic run_episode(input int kind, input int n);
    fill(kind, n);
    build_expect(n);
    @(negedge clk);
    #1 rst_n = 1'b1;
    pll_locked = lk[1];
    for (int e = 2; e <= n; e++) begin
      @(negedge clk);
      #1 pll_locked = lk[e];
    end
    @(negedge clk);
    #1;
    check("pending_events", 32'(exp_q.size()), 32'd0);
    check("final_outputs", 32'(outv()), 32'(model_final));
    pll_locked = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(outv()), 32'(RST_VEC));
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  always @(negedge rst_n) prev = RST_VEC;

  // Monitor: every observed output change must match the next predicted event
  always @(negedge clk) begin
    logic [12:0] cur;
    ev_t ev;
    if (rst_n) begin
      cur = outv();
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", 32'(cur), 32'(prev));
        end else begin
          ev = exp_q.pop_front();
          check("event_edge", 32'(cyc), 32'(ev.edge_no));
          check("event_outputs", 32'(cur), 32'(ev.v));
        end
        prev = cur;
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("power_on_reset_outputs", 32'(outv()), 32'(RST_VEC));
    repeat (2) @(negedge clk);
    run_episode(0, 40);
    run_episode(3, 80);
    run_episode(1, 3400);
    run_episode(2, 40);
    run_episode(4, 60);
    for (int r = 0; r < 8; r++) run_episode(5, 400);
    run_episode(0, 40);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
